// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Drives every operand combination {PB,R,Q,P} into the simple ALU, waits the
// ALU settle latency, samples the result S and hands (index, result) pairs to a
// downstream consumer over a valid/ready handshake. One result is produced per
// vector, P varying fastest and PB slowest, until the last (all-ones) vector
// has been accepted.
//
// Parameters
//   W    operand width of P, Q, R
//   RW   result width of S (must not exceed 16 when the signature is built)
//   LAT  clk_in cycles from operand change to a valid S (1..15)
//
// Ports
//   clk_in     in   1       system clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   start      in   1       begin a sweep (honoured in IDLE/DONE only)
//   abort      in   1       synchronous return to IDLE, beats start/handshake
//   P_out      out  W       operand P to ALU
//   Q_out      out  W       operand Q to ALU
//   R_out      out  W       operand R to ALU
//   PB_out     out  1       mode bit to ALU
//   S_in       in   RW      ALU result
//   res_valid  out  1       res_data/res_idx valid
//   res_ready  in   1       consumer accepts the result
//   res_data   out  RW      captured S
//   res_idx    out  3W+1    vector index {PB,R,Q,P}
//   busy       out  1       high in WAIT/CAPTURE
//   done       out  1       high in DONE
//   sig        out  16      rolling result signature (ALU_SIG_EN builds only)
//
// Build option
//   ALU_SIG_EN  when defined, adds the sig port and its signature register.
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int W   = 4,
    parameter int RW  = 6,
    parameter int LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [W-1:0]      P_out,
    output logic [W-1:0]      Q_out,
    output logic [W-1:0]      R_out,
    output logic              PB_out,
    input  logic [RW-1:0]     S_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RW-1:0]     res_data,
    output logic [3*W:0]      res_idx,
    output logic              busy,
    output logic              done
`ifdef ALU_SIG_EN
    ,
    output logic [15:0]       sig
`endif
);

    localparam int IW = 3 * W + 1;

    // The wait counter is sized for the largest supported latency.
    localparam logic [3:0]    CNT_LAST = 4'(LAT - 1);
    localparam logic [IW-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          res_valid_d;
    logic [RW-1:0] res_data_d;
    logic [IW-1:0] res_idx_d;
    logic          done_d;

`ifdef ALU_SIG_EN
    logic [15:0]   sig_d;

    // Rotate-left by one, then fold in the zero-extended accepted result.
    function automatic logic [15:0] sig_step(input logic [15:0] s,
                                             input logic [RW-1:0] d);
        return {s[14:0], s[15]} ^ {{(16 - RW){1'b0}}, d};
    endfunction
`endif

    // The operand bus is the index register itself, so operands only move
    // when the index does and never glitch between vectors.
    assign {PB_out, R_out, Q_out, P_out} = idx_q;

    assign busy = (state_q == S_WAIT) || (state_q == S_CAPTURE);

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_idx_d   = res_idx;
        done_d      = done;
`ifdef ALU_SIG_EN
        sig_d       = sig;
`endif

        if (abort) begin
            // Abort wins over start and over a pending handshake.
            state_d     = S_IDLE;
            idx_d       = '0;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            res_data_d  = '0;
            res_idx_d   = '0;
            done_d      = 1'b0;
`ifdef ALU_SIG_EN
            sig_d       = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
`ifdef ALU_SIG_EN
                        sig_d   = '0;
`endif
                    end
                end

                S_WAIT: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        res_data_d  = S_in;
                        res_idx_d   = idx_q;
                        res_valid_d = 1'b1;
                        state_d     = S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    // Everything holds until the consumer takes the result.
                    if (res_valid && res_ready) begin
                        res_valid_d = 1'b0;
`ifdef ALU_SIG_EN
                        sig_d       = sig_step(sig, res_data);
`endif
                        if (idx_q == IDX_LAST) begin
                            // Last vector stays on the operand bus.
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            cnt_d   = '0;
                            state_d = S_WAIT;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            done      <= 1'b0;
`ifdef ALU_SIG_EN
            sig       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_idx   <= res_idx_d;
            done      <= done_d;
`ifdef ALU_SIG_EN
            sig       <= sig_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_sequencer
//
// Directed bench for alu_operand_sequencer. The ALU is modelled as S = P+Q+R.
// dut runs with LAT=1; dut4 runs with LAT=4 and an ALU model whose output is
// only correct once the operands have been stable for three cycles, so a
// sequencer that samples early picks up a wrong value.
// -----------------------------------------------------------------------------
module tb_alu_operand_sequencer;

    localparam int W  = 4;
    localparam int RW = 6;
    localparam int IW = 3 * W + 1;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          start, abort, res_ready;
    logic [W-1:0]  p, q, r;
    logic          pb;
    logic [RW-1:0] s_in;
    logic          res_valid, busy, done;
    logic [RW-1:0] res_data;
    logic [IW-1:0] res_idx;
    logic          fault = 1'b0;

    logic          start4, abort4, res_ready4;
    logic [W-1:0]  p4, q4, r4;
    logic          pb4;
    logic [RW-1:0] s_in4;
    logic          res_valid4, busy4, done4;
    logic [RW-1:0] res_data4;
    logic [IW-1:0] res_idx4;
    logic [IW-1:0] prev4 = '0;
    int            stab4 = 0;

`ifdef ALU_SIG_EN
    logic [15:0]   sig, sig4, sig_a;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    assign s_in = (RW'(p) + RW'(q) + RW'(r)) ^ {{(RW-1){1'b0}}, (fault && {pb, r, q, p} == 13'd9)};

    always @(negedge clk_in) begin
        if ({pb4, r4, q4, p4} != prev4) begin
            prev4 <= {pb4, r4, q4, p4};
            stab4 <= 0;
        end else if (stab4 < 15) begin
            stab4 <= stab4 + 1;
        end
    end
    assign s_in4 = (stab4 >= 3) ? (RW'(p4) + RW'(q4) + RW'(r4)) : 6'h2A;

    alu_operand_sequencer #(.W(W), .RW(RW), .LAT(1)) dut (
        .clk_in(clk_in), .rst(rst), .start(start), .abort(abort),
        .P_out(p), .Q_out(q), .R_out(r), .PB_out(pb), .S_in(s_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .busy(busy), .done(done)
`ifdef ALU_SIG_EN
        , .sig(sig)
`endif
    );

    alu_operand_sequencer #(.W(W), .RW(RW), .LAT(4)) dut4 (
        .clk_in(clk_in), .rst(rst), .start(start4), .abort(abort4),
        .P_out(p4), .Q_out(q4), .R_out(r4), .PB_out(pb4), .S_in(s_in4),
        .res_valid(res_valid4), .res_ready(res_ready4), .res_data(res_data4),
        .res_idx(res_idx4), .busy(busy4), .done(done4)
`ifdef ALU_SIG_EN
        , .sig(sig4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idx(input logic [IW-1:0] tgt, input int budget, input string tag);
        int n = 0;
        while (!(res_valid && res_idx == tgt) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_done(output int hs, output logic [IW-1:0] li, output logic [RW-1:0] ld);
        int n = 0;
        hs = 0;
        li = '0;
        ld = '0;
        while (!done && n < 20000) begin
            if (res_valid && res_ready) begin
                hs++;
                li = res_idx;
                ld = res_data;
            end
            step();
            n++;
        end
        chk("done_timeout", 32'(n < 20000), 32'd1);
    endtask

    function automatic logic [15:0] sig_model();
        logic [15:0]   s;
        logic [RW-1:0] v;
        s = '0;
        for (int i = 0; i < 8192; i++) begin
            v = RW'(i[3:0]) + RW'(i[7:4]) + RW'(i[11:8]);
            s = {s[14:0], s[15]} ^ {{(16-RW){1'b0}}, v};
        end
        return s;
    endfunction

    initial begin
        int            hs, t0, prev;
        logic [IW-1:0] li;
        logic [RW-1:0] ld;

        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        start4 = 1'b0; abort4 = 1'b0; res_ready4 = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy_done", {30'd0, busy, done}, 0);
        chk("rst_operands", 32'({pb, r, q, p}), 0);
        chk("rst_res", {res_data, res_idx}, 0);
        rst = 1'b0;
        step();

        // Test 1: first results and selected indices
        start = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
        chk("t1_busy", {30'd0, busy, res_valid}, 32'd2);
        step();
        chk("t1_first_valid", {res_valid, res_idx, res_data}, {1'b1, 13'd0, 6'd0});
        step();
        chk("t1_advance", {res_valid, 28'(p)}, {1'b0, 28'd1});
        step();
        chk("t1_second", {res_valid, res_idx}, {1'b1, 13'd1});
        chk("t1_rate", cyc - t0, 3);
        wait_idx(13'd17, 100, "t1_wait17");
        chk("t1_idx17", 32'(res_data), 2);
        wait_idx(13'd4095, 10000, "t1_wait4095");
        chk("t1_idx4095", 32'(res_data), 45);
        wait_done(hs, li, ld);

        // Test 2: full sweep accounting
        start = 1'b1;
        step();
        t0 = cyc;
        start = 1'b0;
        wait_done(hs, li, ld);
        chk("t2_handshakes", hs, 8192);
        chk("t2_last_idx", 32'(li), 8191);
        chk("t2_last_data", 32'(ld), 45);
        chk("t2_cycles", cyc - t0, 16384);
        chk("t2_flags", {29'd0, done, busy, res_valid}, 32'd4);
        chk("t2_operands", 32'({pb, r, q, p}), 32'h1FFF);
        repeat (3) step();
        chk("t2_done_hold", 32'(done), 1);
`ifdef ALU_SIG_EN
        chk("t6_sig_golden", 32'(sig), 32'(sig_model()));
        sig_a = sig;
`endif

        // Test 3: back-pressure at idx 5
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idx(13'd5, 100, "t3_wait5");
        res_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t3_hold", {res_valid, 7'(res_data), 8'(p), res_idx}, {1'b1, 7'd5, 8'd5, 13'd5});
        end
        res_ready = 1'b1;
        step();
        chk("t3_release", 32'(res_valid), 0);
        step();
        chk("t3_next", {res_valid, res_idx}, {1'b1, 13'd6});

        // start while busy must not restart the sweep
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_busy_start", {res_valid, res_idx}, {1'b1, 13'd7});

        // Test 5a: abort at idx 300, with a simultaneous start
        wait_idx(13'd300, 1000, "t5_wait300a");
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_abort_flags", {29'd0, busy, done, res_valid}, 0);
        chk("t5_abort_out", {6'(pb), res_idx, 13'({r, q, p})}, 0);
        repeat (2) step();
        chk("t5_abort_idle", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_abort_restart", {res_valid, res_idx}, {1'b1, 13'd0});

        // Test 5b: asynchronous reset at idx 300
        wait_idx(13'd300, 1000, "t5_wait300b");
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_async", {res_valid, busy, done, res_idx, 13'({pb, r, q, p})}, 0);
        step();
        rst = 1'b0;
        step();
        chk("t5_rst_idle", {30'd0, busy, res_valid}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_rst_restart", {res_valid, res_idx, res_data}, {1'b1, 13'd0, 6'd0});

        // Test 4: LAT=4 timing and late-settling ALU output
        prev = cyc;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!res_valid4 && n < 20) begin
                step();
                n++;
            end
            chk("t4_gap", cyc - prev, 5);
            chk("t4_result", {res_idx4, res_data4}, {13'(k), 6'(k)});
            chk("t4_flags", {busy4, done4}, 32'd2);
            prev = cyc;
            step();
        end

`ifdef ALU_SIG_EN
        // Test 6: repeat sweep matches, corrupted idx 9 does not
        wait_done(hs, li, ld);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(hs, li, ld);
        chk("t6_sig_repeat", 32'(sig), 32'(sig_a));
        fault = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(hs, li, ld);
        fault = 1'b0;
        chk("t6_sig_fault", 32'(sig != sig_a), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
